bsg_chip_io_link_reset_sequencer: RTL and testbench
===================================================

Name: bsg_chip_io_link_reset_sequencer

Overview:
- Single-clock bring-up controller for one IO link pod (DDR upstream/downstream links, channel tunnel, hop FIFOs).
- Generates the ordered reset sequence those blocks require:
  - assert all resets;
  - pulse the async token reset;
  - release the IO-side links, then the core-side links, then the channel tunnel, then the hop FIFOs.
- Outputs are flop-driven levels. IO-domain outputs are carried across by downstream bsg_sync_sync; this block does no CDC.

Parameters:
- step_cycles_p, 16: clk_i cycles each sequencing step is held; legal range ≥1.
- lg_step_cycles_lp, `BSG_SAFE_CLOG2(step_cycles_p)`: step counter width (localparam).

Ports:
- clk_i, input, 1: sequencer clock (core clock).
- reset_i, input, 1: asynchronous active-high reset.
- start_i, input, 1: level-sampled request to (re)run the sequence.
- hold_i, input, 1: freezes the step counter; all outputs stay unchanged.
- io_up_link_reset_o, output, 1: IO-domain upstream link reset.
- io_down_link_reset_o, output, 1: IO-domain downstream link reset.
- async_token_reset_o, output, 1: upstream async token reset.
- core_up_link_reset_o, output, 1: core upstream link reset.
- core_down_link_reset_o, output, 1: core downstream link reset.
- ct_reset_o, output, 1: channel tunnel and tunnel FIFO reset.
- fifo_reset_o, output, 1: hop FIFO reset.
- busy_o, output, 1: sequence in progress.
- done_o, output, 1: sequence complete and link released.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk_i, reset_i).
- While reset_i is high, and immediately on its assertion:
  - state=IDLE, counter=0;
  - all *_reset_o=1 except async_token_reset_o=0;
  - busy_o=0, done_o=0.
- All outputs come from flops (state-decoded registers); no combinational path from inputs to outputs.
- States, in order: IDLE, ASSERT, TOKEN, TOKEN_CLR, IO_UP, IO_DOWN, CORE_LINK, CT, FIFO, DONE.
- Output values per state (a released reset stays released in all later states):
  - IDLE, ASSERT, TOKEN_CLR: all resets=1, token=0.
  - TOKEN: all resets=1, token=1.
  - IO_UP: io_up_link_reset_o=0.
  - IO_DOWN: additionally io_down_link_reset_o=0.
  - CORE_LINK: additionally core_up_link_reset_o=0 and core_down_link_reset_o=0.
  - CT: additionally ct_reset_o=0.
  - FIFO and DONE: additionally fifo_reset_o=0, i.e. all resets=0, token=0.
- busy_o=1 in ASSERT through FIFO. done_o=1 only in DONE.
- Transitions:
  - IDLE→ASSERT when start_i=1 at a clock edge.
  - Each state ASSERT..FIFO loads counter=step_cycles_p-1 on entry and decrements each cycle with hold_i=0.
  - When counter==0 and hold_i=0, advance to the next state. FIFO advances to DONE.
  - Each step therefore lasts exactly step_cycles_p un-held cycles.
- Latency: start_i sampled at edge k gives ASSERT after edge k and DONE after edge k+8*step_cycles_p, with hold_i=0 throughout.
- Restart: start_i=1 in any state other than IDLE forces ASSERT on the next edge, reloading the counter. All resets reassert, token goes to 0, and done_o drops.
  - start_i has priority over hold_i and over step advance.
  - start_i held high continuously keeps the block in ASSERT.
- hold_i=1: counter and state frozen, no output change; start_i still restarts.
- step_cycles_p=1: every step lasts one cycle and the counter is constant 0.
- DONE is terminal until start_i or reset_i.
- Reset mid-sequence returns to IDLE asynchronously with the reset values above.

Test Plan:
- Reset release (step_cycles_p=4): deassert reset_i with start_i=0 → outputs hold reset values (resets=1, token=0, busy_o=0, done_o=0) for ≥20 cycles.
- Full sequence (step_cycles_p=4): start_i pulse at edge 0 → expect:
  - token=1 after edges 4–7, 0 after edge 8;
  - io_up=0 from edge 12, io_down=0 from edge 16;
  - core links=0 from edge 20, ct=0 from edge 24, fifo=0 from edge 28;
  - done_o=1 from edge 32, busy_o=1 only over edges 0–31.
- Hold: assert hold_i for 10 cycles during TOKEN → token stays 1 and done_o is delayed to edge 42.
- Restart from DONE and mid-CT: start_i pulse → next edge all resets=1, token=0, done_o=0; the full 32-cycle sequence repeats.
- Async reset at edge 18 (mid-IO_DOWN), asserted between edges → outputs return to reset values before the next edge; state=IDLE; no further progress until start_i.
- step_cycles_p=1: start_i pulse → done_o after exactly 8 edges, each output changing on consecutive edges.

Source files
------------

// File: rtl/bsg_chip_io_link_reset_sequencer.sv
// +----------------------------------------------------------------------------+
// | bsg_chip_io_link_reset_sequencer: ordered reset bring-up for one IO link pod |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_chip_io_link_reset_sequencer #(
  parameter int step_cycles_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic hold_i,
  output logic io_up_link_reset_o,
  output logic io_down_link_reset_o,
  output logic async_token_reset_o,
  output logic core_up_link_reset_o,
  output logic core_down_link_reset_o,
  output logic ct_reset_o,
  output logic fifo_reset_o,
  output logic busy_o,
  output logic done_o
);

  localparam int lg_step_cycles_lp = `BSG_SAFE_CLOG2(step_cycles_p);
  localparam logic [lg_step_cycles_lp-1:0] step_load_lp = lg_step_cycles_lp'(step_cycles_p - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ASSERT    = 4'd1,
    TOKEN     = 4'd2,
    TOKEN_CLR = 4'd3,
    IO_UP     = 4'd4,
    IO_DOWN   = 4'd5,
    CORE_LINK = 4'd6,
    CT        = 4'd7,
    FIFO      = 4'd8,
    DONE      = 4'd9
  } state_e;

  state_e state_q, state_d, state_next;
  logic [lg_step_cycles_lp-1:0] cnt_q, cnt_d;

  logic io_up_q, io_down_q, token_q, core_up_q, core_down_q, ct_q, fifo_q, busy_q, done_q;
  logic io_up_d, io_down_d, token_d, core_up_d, core_down_d, ct_d, fifo_d, busy_d, done_d;

  always_comb begin
    state_next = state_q;
    case (state_q)
      ASSERT:    state_next = TOKEN;
      TOKEN:     state_next = TOKEN_CLR;
      TOKEN_CLR: state_next = IO_UP;
      IO_UP:     state_next = IO_DOWN;
      IO_DOWN:   state_next = CORE_LINK;
      CORE_LINK: state_next = CT;
      CT:        state_next = FIFO;
      FIFO:      state_next = DONE;
      default:   state_next = state_q;
    endcase
  end

  // start_i wins over hold_i and over the step advance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = ASSERT;
      cnt_d   = step_load_lp;
    end else if (state_q != IDLE && state_q != DONE && !hold_i) begin
      if (cnt_q == '0) begin
        state_d = state_next;
        cnt_d   = step_load_lp;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they track state_q
  always_comb begin
    io_up_d     = state_d inside {IDLE, ASSERT, TOKEN, TOKEN_CLR};
    io_down_d   = state_d inside {IDLE, ASSERT, TOKEN, TOKEN_CLR, IO_UP};
    core_up_d   = state_d inside {IDLE, ASSERT, TOKEN, TOKEN_CLR, IO_UP, IO_DOWN};
    core_down_d = core_up_d;
    ct_d        = state_d inside {IDLE, ASSERT, TOKEN, TOKEN_CLR, IO_UP, IO_DOWN, CORE_LINK};
    fifo_d      = state_d inside {IDLE, ASSERT, TOKEN, TOKEN_CLR, IO_UP, IO_DOWN, CORE_LINK, CT};
    token_d     = (state_d == TOKEN);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      io_up_q     <= 1'b1;
      io_down_q   <= 1'b1;
      token_q     <= 1'b0;
      core_up_q   <= 1'b1;
      core_down_q <= 1'b1;
      ct_q        <= 1'b1;
      fifo_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_up_q     <= io_up_d;
      io_down_q   <= io_down_d;
      token_q     <= token_d;
      core_up_q   <= core_up_d;
      core_down_q <= core_down_d;
      ct_q        <= ct_d;
      fifo_q      <= fifo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign io_up_link_reset_o     = io_up_q;
  assign io_down_link_reset_o   = io_down_q;
  assign async_token_reset_o    = token_q;
  assign core_up_link_reset_o   = core_up_q;
  assign core_down_link_reset_o = core_down_q;
  assign ct_reset_o             = ct_q;
  assign fifo_reset_o           = fifo_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_chip_io_link_reset_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_bsg_chip_io_link_reset_sequencer: step=4 and step=1 sequencers vs model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bsg_chip_io_link_reset_sequencer;

  localparam int STEP0 = 4;
  localparam int STEP1 = 1;

  logic clk = 1'b0;
  logic rst, start, hold;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  logic [8:0] obs [2];

  bsg_chip_io_link_reset_sequencer #(.step_cycles_p(STEP0)) dut0 (
    .clk_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold),
    .io_up_link_reset_o(obs[0][8]), .io_down_link_reset_o(obs[0][7]),
    .async_token_reset_o(obs[0][6]), .core_up_link_reset_o(obs[0][5]),
    .core_down_link_reset_o(obs[0][4]), .ct_reset_o(obs[0][3]),
    .fifo_reset_o(obs[0][2]), .busy_o(obs[0][1]), .done_o(obs[0][0])
  );

  bsg_chip_io_link_reset_sequencer #(.step_cycles_p(STEP1)) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold),
    .io_up_link_reset_o(obs[1][8]), .io_down_link_reset_o(obs[1][7]),
    .async_token_reset_o(obs[1][6]), .core_up_link_reset_o(obs[1][5]),
    .core_down_link_reset_o(obs[1][4]), .ct_reset_o(obs[1][3]),
    .fifo_reset_o(obs[1][2]), .busy_o(obs[1][1]), .done_o(obs[1][0])
  );

  // Model: idle flag plus count of un-held cycles since the last start
  bit m_idle [2];
  int m_el   [2];

  function automatic int step_of(int d);
    return (d == 0) ? STEP0 : STEP1;
  endfunction

  // {io_up, io_down, token, core_up, core_down, ct, fifo, busy, done}
  function automatic logic [8:0] model_exp(int d);
    int stage;
    if (m_idle[d]) return 9'b1_1011_1100;
    stage = m_el[d] / step_of(d);
    return {stage < 3, stage < 4, stage == 1, stage < 5, stage < 5,
            stage < 6, stage < 7, stage < 8, stage >= 8};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idle[d] = 1'b1;
      m_el[d]   = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_idle[d] = 1'b1;
        m_el[d]   = 0;
      end else if (start) begin
        m_idle[d] = 1'b0;
        m_el[d]   = 0;
      end else if (!m_idle[d] && !hold && m_el[d] < 8 * step_of(d)) begin
        m_el[d]++;
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [8:0] e;
    for (int d = 0; d < 2; d++) begin
      e = model_exp(d);
      compared++;
      assert (obs[d] === e) else begin
        mismatched++;
        $error("FAIL %s dut%0d observed=%b expected=%b", tag, d, obs[d], e);
      end
    end
  endtask

  task automatic tick(input logic s, input logic h, input string tag);
    start = s;
    hold  = h;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check(tag);
    tick(1'b0, 1'b0, tag);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1 check("reset_assert");
    tick(1'b0, 1'b0, "reset_held");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, "reset_release_idle");

    // Full sequence then idle in DONE
    tick(1'b1, 1'b0, "full_start");
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, "full_seq");

    // Hold during TOKEN: done_o lands on edge 42
    tick(1'b1, 1'b0, "hold_start");
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(1'b0, 1'b0, "hold_pre"); n++; end
    for (int i = 0; i < 10; i++) begin tick(1'b0, 1'b1, "hold_frozen"); n++; end
    while (obs[0][0] !== 1'b1 && n < 100) begin tick(1'b0, 1'b0, "hold_post"); n++; end
    compared++;
    assert (n == 42) else begin
      mismatched++;
      $error("FAIL hold_done_edge observed=%0d required=42", n);
    end

    // Restart from DONE, then restart mid-CT
    tick(1'b1, 1'b0, "restart_done");
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, "run_to_ct");
    tick(1'b1, 1'b0, "restart_ct");
    for (int i = 0; i < 34; i++) tick(1'b0, 1'b0, "restart_seq");

    // Start held high keeps ASSERT
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, "start_held");
    tick(1'b1, 1'b1, "start_over_hold");

    // Async reset mid IO_DOWN (edge 18), no progress afterwards without start
    tick(1'b1, 1'b0, "rst_mid_start");
    for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, "rst_mid_run");
    async_reset_pulse("async_rst_mid");
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, "after_rst_idle");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset_pulse("rand_async_rst");
      else tick($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
